ghost_keygen: RTL

Producer side of the ghost direction-keycode interface. Generates the pseudo-random movement keycode (8'h1A left, 8'h04 right, 8'h07 down, 8'h16 up, 8'h00 none) that drives each ghost movement module. Uses an LFSR, per-frame hold timers and the same wall-sense inputs the ghost uses. The ghost therefore only ever receives a keycode for an open direction. One instance per ghost; each instance has a distinct SEED.

---
 rtl/ghost_keygen.sv | 104 ++++++++++
 1 files changed

// File: rtl/ghost_keygen.sv
// ghost_keygen: LFSR-driven ghost direction keycode generator; GHOST_KEYGEN_NOREVERSE_EN bars picking the reverse of the current code.
module ghost_keygen #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int START_DELAY = 3,
  parameter int MIN_HOLD = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       restart,
  input  logic       sec,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] randomkeycode
);
  typedef enum logic [1:0] {WAIT, PICK, MOVE} state_t;
  localparam logic [5:0] HOLD_BASE = 6'(MIN_HOLD);
  localparam logic [3:0] SEC_LAST = 4'(START_DELAY - 1);
  state_t state;
  logic [15:0] lfsr, lfsr_nxt;
  logic [5:0] hold_cnt;
  logic [3:0] sec_cnt;
  logic frame_clk_d, sec_d, frame_tick, sec_tick;
  logic [3:0] open, elig;
  logic [1:0] cur_dir, pick_dir, idx;
  logic have_dir, cur_blocked, pick_ok;
`ifdef GHOST_KEYGEN_NOREVERSE_EN
  logic [3:0] excl;
`endif
  function automatic logic [7:0] code_of(input logic [1:0] d);
    return d == 2'd0 ? 8'h1A : d == 2'd1 ? 8'h04 : d == 2'd2 ? 8'h07 : 8'h16;
  endfunction
  assign frame_tick = frame_clk & ~frame_clk_d;
  assign sec_tick = sec & ~sec_d;
  assign lfsr_nxt = lfsr == 16'h0000 ? SEED : lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
  // index order L, R, D, U; reverse of index d is d ^ 1
  assign open = {~|mapT, ~|mapB, ~|mapR, ~|mapL};
  assign have_dir = |randomkeycode;
  assign cur_dir = randomkeycode == 8'h04 ? 2'd1 : randomkeycode == 8'h07 ? 2'd2 :
                   randomkeycode == 8'h16 ? 2'd3 : 2'd0;
  assign cur_blocked = have_dir & ~open[cur_dir];
  always_comb begin
    elig = open;
`ifdef GHOST_KEYGEN_NOREVERSE_EN
    excl = have_dir ? 4'b0001 << (cur_dir ^ 2'd1) : 4'b0000;
    elig = |(open & ~excl) ? open & ~excl : open;
`endif
    pick_ok = 1'b0;
    pick_dir = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = lfsr[1:0] + 2'(k);
      if (elig[idx]) begin
        pick_ok = 1'b1;
        pick_dir = idx;
      end
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= WAIT;
      randomkeycode <= 8'h00;
      lfsr <= SEED;
      hold_cnt <= 6'd0;
      sec_cnt <= 4'd0;
      frame_clk_d <= 1'b0;
      sec_d <= 1'b0;
    end else begin
      lfsr <= lfsr_nxt;
      frame_clk_d <= frame_clk;
      sec_d <= sec;
      if (restart) begin
        state <= WAIT;
        randomkeycode <= 8'h00;
        sec_cnt <= 4'd0;
        hold_cnt <= 6'd0;
      end else begin
        case (state)
          WAIT: begin
            randomkeycode <= 8'h00;
            if (sec_tick) begin
              sec_cnt <= sec_cnt == SEC_LAST ? 4'd0 : sec_cnt + 4'd1;
              if (sec_cnt == SEC_LAST) state <= PICK;
            end
          end
          PICK: begin
            if (pick_ok) randomkeycode <= code_of(pick_dir);
            hold_cnt <= HOLD_BASE + {2'b00, lfsr[5:2]};
            state <= MOVE;
          end
          MOVE: begin
            if (frame_tick) begin
              if (hold_cnt != 6'd0) hold_cnt <= hold_cnt - 6'd1;
              if (hold_cnt == 6'd1 || cur_blocked) state <= PICK;
            end
          end
          default: state <= WAIT;
        endcase
      end
    end
  end
endmodule
